// File: rtl/rf_writeback_if.sv
// Bundle of producer handshakes, load-issue, register-file write port and
// scoreboard signals for the register-file writeback unit.
interface rf_writeback_if #(
    parameter int DATA_W = 32
);
    logic              issue_valid;
    logic [4:0]        issue_rd;

    logic              alu_valid;
    logic              alu_ready;
    logic [4:0]        alu_rd;
    logic [DATA_W-1:0] alu_wd;

    logic              mem_valid;
    logic              mem_ready;
    logic [4:0]        mem_rd;
    logic [DATA_W-1:0] mem_wd;

    logic              rf_we;
    logic [4:0]        rf_rd;
    logic [DATA_W-1:0] rf_wd;

    logic [31:0]       busy;

    // Producer / decode side: drives requests, observes grants and RF port.
    modport master (
        output issue_valid, issue_rd,
        output alu_valid, alu_rd, alu_wd,
        input  alu_ready,
        output mem_valid, mem_rd, mem_wd,
        input  mem_ready,
        input  rf_we, rf_rd, rf_wd, busy
    );

    // Writeback unit side.
    modport slave (
        input  issue_valid, issue_rd,
        input  alu_valid, alu_rd, alu_wd,
        output alu_ready,
        input  mem_valid, mem_rd, mem_wd,
        output mem_ready,
        output rf_we, rf_rd, rf_wd, busy
    );
endinterface

// File: rtl/rf_writeback.sv
// Register-file writeback unit: round-robin arbitration between the ALU and
// the load unit, one registered write per cycle, and a pending-load
// scoreboard that blocks ALU writes to registers with an outstanding load.
module rf_writeback #(
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    rf_writeback_if.slave bus
);

    logic              rf_we_q, rf_we_d;
    logic [4:0]        rf_rd_q, rf_rd_d;
    logic [DATA_W-1:0] rf_wd_q, rf_wd_d;
    logic [31:0]       busy_q, busy_d;
    logic              last_q, last_d;

    logic              alu_elig;
    logic              mem_elig;
    logic              grant_alu;
    logic              grant_mem;

    // Eligibility and round-robin grant; an older pending load blocks the ALU.
    always_comb begin
        alu_elig  = bus.alu_valid && !((bus.alu_rd != 5'd0) && busy_q[bus.alu_rd]);
        mem_elig  = bus.mem_valid;
        grant_mem = mem_elig && (!alu_elig || !last_q);
        grant_alu = alu_elig && !grant_mem;
    end

    assign bus.alu_ready = grant_alu && !rst;
    assign bus.mem_ready = grant_mem && !rst;

    // Next write-port contents, arbitration pointer and scoreboard.
    always_comb begin
        rf_we_d = 1'b0;
        rf_rd_d = rf_rd_q;
        rf_wd_d = rf_wd_q;
        last_d  = last_q;
        busy_d  = busy_q;

        if (grant_mem) begin
            last_d = 1'b1;
            if (bus.mem_rd != 5'd0) begin
                rf_we_d = 1'b1;
                rf_rd_d = bus.mem_rd;
                rf_wd_d = bus.mem_wd;
                busy_d[bus.mem_rd] = 1'b0;
            end
        end else if (grant_alu) begin
            last_d = 1'b0;
            if (bus.alu_rd != 5'd0) begin
                rf_we_d = 1'b1;
                rf_rd_d = bus.alu_rd;
                rf_wd_d = bus.alu_wd;
            end
        end

        if (bus.issue_valid && (bus.issue_rd != 5'd0)) begin
            busy_d[bus.issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_q <= 1'b0;
            rf_rd_q <= '0;
            rf_wd_q <= '0;
            busy_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            rf_we_q <= rf_we_d;
            rf_rd_q <= rf_rd_d;
            rf_wd_q <= rf_wd_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
        end
    end

    assign bus.rf_we = rf_we_q;
    assign bus.rf_rd = rf_rd_q;
    assign bus.rf_wd = rf_wd_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_rf_writeback.sv
// Directed bench for rf_writeback: reset, contention, WAW blocking, x0,
// scoreboard collisions and reset mid-stream.
module tb_rf_writeback;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rf_writeback_if #(.DATA_W(32)) bus ();

    rf_writeback #(.DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its expected value.
    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive all request inputs in one call.
    task automatic apply_stimulus(input logic iv, input logic [4:0] ird,
                                  input logic av, input logic [4:0] ard, input logic [31:0] awd,
                                  input logic mv, input logic [4:0] mrd, input logic [31:0] mwd);
        bus.issue_valid = iv;
        bus.issue_rd    = ird;
        bus.alu_valid   = av;
        bus.alu_rd      = ard;
        bus.alu_wd      = awd;
        bus.mem_valid   = mv;
        bus.mem_rd      = mrd;
        bus.mem_wd      = mwd;
        #1;
    endtask

    // Directed sequence.
    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();

        // Reset state
        check_output("rst_we",   {31'd0, bus.rf_we}, 32'd0);
        check_output("rst_rd",   {27'd0, bus.rf_rd}, 32'd0);
        check_output("rst_wd",   bus.rf_wd, 32'd0);
        check_output("rst_busy", bus.busy, 32'd0);

        // Requests during reset are not accepted
        apply_stimulus(0, 0, 1, 5'd5, 32'hDEADBEEF, 1, 5'd8, 32'h80);
        check_output("rst_alu_ready", {31'd0, bus.alu_ready}, 32'd0);
        check_output("rst_mem_ready", {31'd0, bus.mem_ready}, 32'd0);

        // First ALU write after reset
        rst = 1'b0;
        apply_stimulus(0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        check_output("alu_ready_first", {31'd0, bus.alu_ready}, 32'd1);
        check_output("mem_ready_first", {31'd0, bus.mem_ready}, 32'd0);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        check_output("first_we", {31'd0, bus.rf_we}, 32'd1);
        check_output("first_rd", {27'd0, bus.rf_rd}, 32'd5);
        check_output("first_wd", bus.rf_wd, 32'hDEADBEEF);

        // Contention: mem, ALU, mem, ALU
        apply_stimulus(0, 0, 1, 5'd1, 32'h11, 1, 5'd8, 32'h80);
        check_output("cont0_mem_ready", {31'd0, bus.mem_ready}, 32'd1);
        check_output("cont0_alu_ready", {31'd0, bus.alu_ready}, 32'd0);
        tick();
        apply_stimulus(0, 0, 1, 5'd1, 32'h11, 1, 5'd9, 32'h90);
        check_output("cont1_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
        check_output("cont1_mem_ready", {31'd0, bus.mem_ready}, 32'd0);
        check_output("cont1_rd", {27'd0, bus.rf_rd}, 32'd8);
        check_output("cont1_wd", bus.rf_wd, 32'h80);
        tick();
        apply_stimulus(0, 0, 1, 5'd2, 32'h22, 1, 5'd9, 32'h90);
        check_output("cont2_mem_ready", {31'd0, bus.mem_ready}, 32'd1);
        check_output("cont2_we", {31'd0, bus.rf_we}, 32'd1);
        check_output("cont2_rd", {27'd0, bus.rf_rd}, 32'd1);
        check_output("cont2_wd", bus.rf_wd, 32'h11);
        tick();
        apply_stimulus(0, 0, 1, 5'd2, 32'h22, 1, 5'd10, 32'hA0);
        check_output("cont3_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
        check_output("cont3_rd", {27'd0, bus.rf_rd}, 32'd9);
        check_output("cont3_wd", bus.rf_wd, 32'h90);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        check_output("cont4_we", {31'd0, bus.rf_we}, 32'd1);
        check_output("cont4_rd", {27'd0, bus.rf_rd}, 32'd2);
        check_output("cont4_wd", bus.rf_wd, 32'h22);

        // WAW: load to x7 blocks the ALU write to x7
        apply_stimulus(1, 5'd7, 0, 0, 0, 0, 0, 0);
        tick();
        apply_stimulus(0, 0, 1, 5'd7, 32'hA1, 0, 0, 0);
        check_output("waw_busy", bus.busy, 32'h0000_0080);
        check_output("waw_alu_blocked", {31'd0, bus.alu_ready}, 32'd0);
        check_output("idle_we", {31'd0, bus.rf_we}, 32'd0);
        check_output("idle_rd_hold", {27'd0, bus.rf_rd}, 32'd2);
        check_output("idle_wd_hold", bus.rf_wd, 32'h22);
        tick();
        apply_stimulus(0, 0, 1, 5'd7, 32'hA1, 1, 5'd7, 32'h3E3);
        check_output("waw_alu_still_blocked", {31'd0, bus.alu_ready}, 32'd0);
        check_output("waw_mem_ready", {31'd0, bus.mem_ready}, 32'd1);
        tick();
        apply_stimulus(0, 0, 1, 5'd7, 32'hA1, 0, 0, 0);
        check_output("waw_busy_clear", bus.busy, 32'd0);
        check_output("waw_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
        check_output("waw_mem_wd", bus.rf_wd, 32'h3E3);
        check_output("waw_mem_rd", {27'd0, bus.rf_rd}, 32'd7);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        check_output("waw_alu_we", {31'd0, bus.rf_we}, 32'd1);
        check_output("waw_alu_wd", bus.rf_wd, 32'hA1);

        // x0: ALU write accepted but not performed; load issue to x0 ignored
        apply_stimulus(1, 5'd0, 1, 5'd0, 32'h55, 0, 0, 0);
        check_output("x0_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        check_output("x0_we", {31'd0, bus.rf_we}, 32'd0);
        check_output("x0_busy", bus.busy, 32'd0);

        // Scoreboard collision on the same register: set wins
        apply_stimulus(1, 5'd3, 0, 0, 0, 0, 0, 0);
        tick();
        apply_stimulus(1, 5'd3, 0, 0, 0, 1, 5'd3, 32'h33);
        check_output("coll_busy_pre", bus.busy, 32'h0000_0008);
        check_output("coll_mem_ready", {31'd0, bus.mem_ready}, 32'd1);
        tick();
        apply_stimulus(1, 5'd4, 0, 0, 0, 1, 5'd3, 32'h34);
        check_output("coll_same_busy", bus.busy, 32'h0000_0008);
        check_output("coll_same_rd", {27'd0, bus.rf_rd}, 32'd3);
        tick();
        apply_stimulus(1, 5'd7, 1, 5'd9, 32'h99, 0, 0, 0);
        check_output("coll_diff_busy", bus.busy, 32'h0000_0010);
        check_output("coll_diff_wd", bus.rf_wd, 32'h34);
        tick();

        // Reset mid-stream with a write pending and loads outstanding
        rst = 1'b1;
        apply_stimulus(0, 0, 1, 5'd10, 32'hAA, 1, 5'd11, 32'hBB);
        check_output("mid_busy_pre", bus.busy, 32'h0000_0090);
        check_output("mid_we_pre", {31'd0, bus.rf_we}, 32'd1);
        check_output("mid_alu_ready", {31'd0, bus.alu_ready}, 32'd0);
        check_output("mid_mem_ready", {31'd0, bus.mem_ready}, 32'd0);
        tick();
        check_output("mid_busy", bus.busy, 32'd0);
        check_output("mid_we", {31'd0, bus.rf_we}, 32'd0);
        check_output("mid_rd", {27'd0, bus.rf_rd}, 32'd0);
        check_output("mid_wd", bus.rf_wd, 32'd0);

        // After reset the arbitration pointer favours mem on a tie
        rst = 1'b0;
        apply_stimulus(0, 0, 1, 5'd10, 32'hAA, 1, 5'd11, 32'hBB);
        check_output("post_mem_ready", {31'd0, bus.mem_ready}, 32'd1);
        check_output("post_alu_ready", {31'd0, bus.alu_ready}, 32'd0);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        check_output("post_rd", {27'd0, bus.rf_rd}, 32'd11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_writeback.md
# rf_writeback

Writeback unit that owns the write port of the 32 x 32-bit integer register file (`we`, `rd`, `wd`). It arbitrates between two result producers, the ALU and the load/memory unit, with valid/ready handshakes, and presents one registered write per cycle. It keeps a pending-load scoreboard so decode can stall on RAW hazards, and it blocks ALU writes that would be overwritten by an older outstanding load (WAW).

## Interface
- `DATA_W`, 32, register data width; must match the register file.
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `issue_valid`  in  1  decode issues a load this cycle.
- `issue_rd`  in  5  destination register of the issued load.
- `alu_valid`  in  1  ALU result available.
- `alu_ready`  out  1  ALU result accepted this cycle (combinational).
- `alu_rd`  in  5  ALU destination register.
- `alu_wd`  in  DATA_W  ALU result.
- `mem_valid`  in  1  load result available.
- `mem_ready`  out  1  load result accepted this cycle (combinational).
- `mem_rd`  in  5  load destination register.
- `mem_wd`  in  DATA_W  load data.
- `rf_we`  out  1  register-file write enable (registered).
- `rf_rd`  out  5  register-file write address (registered).
- `rf_wd`  out  DATA_W  register-file write data (registered).
- `busy`  out  32  scoreboard; bit i set means a load to xi is outstanding (registered).

## Operation
- Handshake: a transfer occurs on a posedge where valid && ready. `ready` depends on the current valid, rd and state. It never depends on the other producer's data.
- ALU eligibility: `alu_valid && !(alu_rd != 0 && busy[alu_rd])`. This is the WAW block.
- Mem eligibility: `mem_valid`. Loads are never blocked.
- Arbitration is round-robin with state bit `last` (0 = ALU granted last, 1 = mem granted last).
  - Only one eligible: it is granted.
  - Both eligible: the producer not granted last is granted.
  - `last` updates only on a grant.
- At most one of `alu_ready` / `mem_ready` is high per cycle. Both are 0 while `rst` is high.
- Granted transfer with rd != 0: next cycle `rf_we`=1, `rf_rd`=rd, `rf_wd`=data.
- Granted transfer with rd == 0: the transfer is accepted and consumed, and next cycle `rf_we`=0. x0 is never written.
- No grant: next cycle `rf_we`=0. `rf_rd` and `rf_wd` hold their previous values.
- Scoreboard set: on `issue_valid && issue_rd != 0`, `busy[issue_rd]` <= 1.
- Scoreboard clear: on an accepted mem transfer with `mem_rd != 0`, `busy[mem_rd]` <= 0.
- Set and clear of the same register on the same edge: set wins, because the new load is younger.
- Set and clear of different registers on the same edge: both take effect.
- `busy[0]` is always 0.
- Busy clear is visible one cycle after the mem acceptance. An ALU write to that register is eligible no earlier than that cycle.

## Timing
- Reset values: `rf_we`=0, `rf_rd`=0, `rf_wd`=0, `busy`=0, `last`=0. Mem therefore wins the first tie.
- Latency from acceptance edge to `rf_we` pulse is 1 cycle. The register file commits on the following edge, so the value is readable on rd1/rd2 two edges after acceptance.
- Throughput is one write per cycle, sustained, with back-to-back grants allowed.
- Under continuous contention the grants alternate, so neither producer waits more than 1 cycle for arbitration.
- Reset mid-operation: all state returns to reset values at the reset edge.
  - Outstanding scoreboard bits are dropped.
  - Any transfer presented during reset is not accepted.
  - A write registered before reset is lost if reset coincides with its `rf_we` cycle: `rf_we` is forced to 0.
- Producers hold valid, rd and data stable until accepted. The unit does not check this.

## Test plan
- Reset then idle: after `rst`=1 for 2 cycles, all outputs are 0. `alu_valid`=1, `alu_rd`=5, `alu_wd`=0xDEADBEEF -> `alu_ready`=1 the same cycle, then next cycle `rf_we`=1, `rf_rd`=5, `rf_wd`=0xDEADBEEF.
- Contention: both valid for 4 cycles (ALU rd=1..4 with data 0x11..0x44, mem rd=8..11 with data 0x80..0xB0) -> grant order mem, ALU, mem, ALU. `rf_rd` sequence is 8, 1, 9, 2, with no idle cycles.
- WAW block: issue load to x7, then `alu_valid` with `alu_rd`=7 -> `alu_ready`=0 while `busy[7]`=1. The mem result for x7 is accepted, `busy[7]` drops the next cycle, the ALU is accepted that cycle, and `rf_wd` shows the mem data first and the ALU data second.
- x0 handling: an ALU write to x0 is accepted with `rf_we`=0 the next cycle. `issue_valid` with `issue_rd`=0 leaves `busy`=0.
- Scoreboard collision: with `busy[3]`=1, `issue_valid` (rd=3) and a mem acceptance (rd=3) on the same edge -> `busy[3]` stays 1. With different registers (issue rd=4, mem rd=3), `busy[4]`=1 and `busy[3]`=0.
- Reset mid-stream: `busy`=0x00000090 and `rf_we`=1, then assert `rst` -> the next cycle has `busy`=0, `rf_we`=0, and both readies 0 while `rst` is high.
